// File: rtl/chip8_mem_arbiter.sv
// Sole owner of the CHIP-8 byte RAM. Round-robin arbitration between opcode fetch,
// sprite draw and load/store, each served as a locked multi-cycle transaction.
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// F_A0  | fetch: first byte address on the RAM
// F_A1  | fetch: second byte address on the RAM, capture high byte
// F_D1  | fetch: capture low byte, load opcode
// B_A   | byte read: address on the RAM
// B_D   | byte read: capture read data
// W     | byte write: mem_we high for this one cycle
// DONE  | ack pulse for the finished transaction
module chip8_mem_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int RR_RESET_LAST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [15:0]       fetch_opcode,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    output logic              draw_ack,
    output logic [7:0]        draw_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [7:0]        ls_wdata,
    output logic              ls_ack,
    output logic [7:0]        ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, F_A0, F_A1, F_D1, B_A, B_D, W, DONE} state_t;

    state_t            r_state;
    logic [1:0]        r_rr_last;
    logic [1:0]        r_id;
    logic [7:0]        r_hi;
    logic              r_fetch_ack;
    logic              r_draw_ack;
    logic              r_ls_ack;
    logic [15:0]       r_fetch_opcode;
    logic [7:0]        r_draw_rdata;
    logic [7:0]        r_ls_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;

    logic              w_any;
    logic [1:0]        w_win;

    // First requester after the last grant, in the circular order 0,1,2.
    always_comb begin
        w_any = fetch_req | draw_req | ls_req;
        w_win = 2'd0;
        case (r_rr_last)
            2'd0:    w_win = draw_req  ? 2'd1 : (ls_req    ? 2'd2 : 2'd0);
            2'd1:    w_win = ls_req    ? 2'd2 : (fetch_req ? 2'd0 : 2'd1);
            default: w_win = fetch_req ? 2'd0 : (draw_req  ? 2'd1 : 2'd2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rr_last      <= 2'(RR_RESET_LAST);
            r_id           <= 2'd0;
            r_hi           <= 8'd0;
            r_fetch_ack    <= 1'b0;
            r_draw_ack     <= 1'b0;
            r_ls_ack       <= 1'b0;
            r_fetch_opcode <= 16'd0;
            r_draw_rdata   <= 8'd0;
            r_ls_rdata     <= 8'd0;
            r_mem_addr     <= '0;
            r_mem_we       <= 1'b0;
            r_mem_wdata    <= 8'd0;
        end else begin
            r_fetch_ack <= 1'b0;
            r_draw_ack  <= 1'b0;
            r_ls_ack    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id      <= w_win;
                        r_rr_last <= w_win;
                        case (w_win)
                            2'd0: begin
                                r_mem_addr <= fetch_addr;
                                r_state    <= F_A0;
                            end
                            2'd1: begin
                                r_mem_addr <= draw_addr;
                                r_state    <= B_A;
                            end
                            default: begin
                                r_mem_addr  <= ls_addr;
                                r_mem_wdata <= ls_wdata;
                                r_mem_we    <= ls_we;
                                r_state     <= ls_we ? W : B_A;
                            end
                        endcase
                    end
                end
                F_A0: begin
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    r_state    <= F_A1;
                end
                F_A1: begin
                    r_hi    <= mem_rdata;
                    r_state <= F_D1;
                end
                F_D1: begin
                    r_fetch_opcode <= {r_hi, mem_rdata};
                    r_fetch_ack    <= 1'b1;
                    r_state        <= DONE;
                end
                B_A: r_state <= B_D;
                B_D: begin
                    if (r_id == 2'd1) begin
                        r_draw_rdata <= mem_rdata;
                        r_draw_ack   <= 1'b1;
                    end else begin
                        r_ls_rdata <= mem_rdata;
                        r_ls_ack   <= 1'b1;
                    end
                    r_state <= DONE;
                end
                W: begin
                    r_mem_we <= 1'b0;
                    r_ls_ack <= 1'b1;
                    r_state  <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fetch_ack    = r_fetch_ack;
    assign draw_ack     = r_draw_ack;
    assign ls_ack       = r_ls_ack;
    assign fetch_opcode = r_fetch_opcode;
    assign draw_rdata   = r_draw_rdata;
    assign ls_rdata     = r_ls_rdata;
    assign mem_addr     = r_mem_addr;
    assign mem_we       = r_mem_we;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: directed vector table, corner sequences and a
// randomized three-requester run against a shadow-memory reference model.
module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, draw_req, ls_req, ls_we;
    logic [11:0] fetch_addr, draw_addr, ls_addr;
    logic [7:0]  ls_wdata;
    logic        fetch_ack, draw_ack, ls_ack;
    logic [15:0] fetch_opcode;
    logic [7:0]  draw_rdata, ls_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    chip8_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_opcode(fetch_opcode),
        .draw_req(draw_req), .draw_addr(draw_addr), .draw_ack(draw_ack), .draw_rdata(draw_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Synchronous single-port RAM, plus a bench-side port used only for preloading.
    logic [7:0]  ram [0:4095];
    logic        tb_we;
    logic [11:0] tb_addr;
    logic [7:0]  tb_data;
    always @(posedge clk) begin
        if (tb_we) ram[tb_addr] <= tb_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    bit onehot_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (onehot_en)
            chk("ack_onehot", 32'($countones({fetch_ack, draw_ack, ls_ack}) <= 1), 32'd1);
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  id;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t tbl [7];

    function automatic logic ack_of(input logic [1:0] id);
        return (id == 2'd0) ? fetch_ack : (id == 2'd1) ? draw_ack : ls_ack;
    endfunction

    function automatic logic [15:0] data_of(input logic [1:0] id);
        return (id == 2'd0) ? fetch_opcode : (id == 2'd1) ? {8'h00, draw_rdata} : {8'h00, ls_rdata};
    endfunction

    // Raises one request in the current (IDLE) cycle, counted as cycle 0.
    task automatic run_txn(input vec_t v, input bit drop_early, output int lat, output logic [15:0] data,
                           output int we_cnt, output int busy_lo, output logic [11:0] a1, output logic [11:0] a2);
        lat = 0; we_cnt = 0; busy_lo = 0; a1 = '0; a2 = '0; data = '0;
        case (v.id)
            2'd0: begin fetch_req = 1'b1; fetch_addr = v.addr; end
            2'd1: begin draw_req = 1'b1; draw_addr = v.addr; end
            default: begin ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata; end
        endcase
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (drop_early && i == 1) begin fetch_req = 1'b0; draw_req = 1'b0; ls_req = 1'b0; end
            if (i == 1) a1 = mem_addr;
            if (i == 2) a2 = mem_addr;
            if (mem_we) we_cnt++;
            if (!busy) busy_lo++;
            if (ack_of(v.id)) begin
                lat = i;
                data = data_of(v.id);
                break;
            end
        end
        fetch_req = 1'b0; draw_req = 1'b0; ls_req = 1'b0;
    endtask

    // Randomized-phase model state.
    logic [7:0]  shadow [0:4095];
    bit          pend [3];
    int          waits [3];
    logic [11:0] r_a [3];
    logic        r_we;
    logic [7:0]  r_wd;
    logic [7:0]  last_ls_read;

    function automatic logic [11:0] rnd_addr();
        int a;
        a = $urandom_range(0, 15);
        return (a < 8) ? 12'(a) : 12'(12'hFF0 + a);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, we_cnt, busy_lo, ack_cnt, n_acks;
        logic [15:0] data;
        logic [11:0] a1, a2, na;
        int ack_id [$];
        int ack_cyc [$];
        bit just [3];

        fetch_req = 0; draw_req = 0; ls_req = 0; ls_we = 0;
        fetch_addr = '0; draw_addr = '0; ls_addr = '0; ls_wdata = '0;
        tb_we = 0; tb_addr = '0; tb_data = '0;
        rst = 1'b1;

        tbl[0] = '{2'd0, 1'b0, 12'h200, 8'h00, 16'hA22A, 4};
        tbl[1] = '{2'd0, 1'b0, 12'hFFF, 8'h00, 16'h1234, 4};
        tbl[2] = '{2'd2, 1'b1, 12'h300, 8'h5C, 16'h0000, 2};
        tbl[3] = '{2'd2, 1'b0, 12'h300, 8'h00, 16'h005C, 3};
        tbl[4] = '{2'd1, 1'b0, 12'h050, 8'h00, 16'h00F0, 3};
        tbl[5] = '{2'd0, 1'b0, 12'h201, 8'h00, 16'h2A11, 4};
        tbl[6] = '{2'd1, 1'b0, 12'hFFF, 8'h00, 16'h0012, 3};

        poke(12'h200, 8'hA2); poke(12'h201, 8'h2A); poke(12'h202, 8'h11);
        poke(12'hFFF, 8'h12); poke(12'h000, 8'h34); poke(12'h050, 8'hF0);
        do_reset();
        onehot_en = 1'b1;

        chk("rst_busy", 32'(busy), 0);
        chk("rst_acks", 32'({fetch_ack, draw_ack, ls_ack}), 0);
        chk("rst_opcode", 32'(fetch_opcode), 0);
        chk("rst_rdata", 32'({draw_rdata, ls_rdata}), 0);
        chk("rst_mem", 32'({mem_addr, mem_we, mem_wdata}), 0);

        foreach (tbl[k]) begin
            run_txn(tbl[k], 1'b0, lat, data, we_cnt, busy_lo, a1, a2);
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'(tbl[k].exp_lat));
            chk($sformatf("v%0d_data", k), 32'(data), 32'(tbl[k].exp_data));
            chk($sformatf("v%0d_we_cycles", k), 32'(we_cnt), 32'(tbl[k].we));
            chk($sformatf("v%0d_busy", k), 32'(busy_lo), 0);
            if (tbl[k].id == 2'd0) begin
                na = tbl[k].addr + 12'd1;
                chk($sformatf("v%0d_addr_c1", k), 32'(a1), 32'(tbl[k].addr));
                chk($sformatf("v%0d_addr_c2", k), 32'(a2), 32'(na));
            end
            tick();
            chk($sformatf("v%0d_idle_after_done", k), 32'(busy), 0);
        end

        // All three requesting from reset and held high.
        do_reset();
        fetch_req = 1; fetch_addr = 12'h200;
        draw_req = 1; draw_addr = 12'h050;
        ls_req = 1; ls_we = 0; ls_addr = 12'h300;
        for (int i = 1; i <= 30 && ack_id.size() < 4; i++) begin
            tick();
            if (fetch_ack) begin ack_id.push_back(0); ack_cyc.push_back(i); end
            if (draw_ack)  begin ack_id.push_back(1); ack_cyc.push_back(i); end
            if (ls_ack)    begin ack_id.push_back(2); ack_cyc.push_back(i); end
        end
        fetch_req = 0; draw_req = 0; ls_req = 0;
        chk("rr_ack_count", 32'(ack_id.size()), 4);
        while (ack_id.size() < 4) begin ack_id.push_back(-1); ack_cyc.push_back(-1); end
        chk("rr_grant0", 32'(ack_id[0]), 0); chk("rr_cycle0", 32'(ack_cyc[0]), 4);
        chk("rr_grant1", 32'(ack_id[1]), 1); chk("rr_cycle1", 32'(ack_cyc[1]), 8);
        chk("rr_grant2", 32'(ack_id[2]), 2); chk("rr_cycle2", 32'(ack_cyc[2]), 12);
        chk("rr_grant3", 32'(ack_id[3]), 0); chk("rr_cycle3", 32'(ack_cyc[3]), 17);
        tick();

        // Reset landing in F_A1 aborts the fetch silently.
        fetch_req = 1; fetch_addr = 12'h200;
        tick();
        fetch_req = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ack", 32'(fetch_ack), 0);
        chk("rst_mid_opcode", 32'(fetch_opcode), 0);
        chk("rst_mid_rdata", 32'({draw_rdata, ls_rdata}), 0);
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fetch_ack) ack_cnt++;
        end
        chk("rst_mid_no_late_ack", 32'(ack_cnt), 0);
        run_txn(tbl[5], 1'b0, lat, data, we_cnt, busy_lo, a1, a2);
        chk("rst_mid_refetch_lat", 32'(lat), 4);
        chk("rst_mid_refetch_data", 32'(data), 32'h2A11);
        tick();

        // Draw request withdrawn during B_A still completes.
        run_txn(tbl[4], 1'b1, lat, data, we_cnt, busy_lo, a1, a2);
        chk("drop_draw_lat", 32'(lat), 3);
        chk("drop_draw_data", 32'(data), 32'hF0);
        tick();

        // Randomized contention against a shadow memory.
        for (int a = 0; a < 16; a++) begin
            na = (a < 8) ? 12'(a) : 12'(12'hFF0 + a);
            shadow[na] = 8'($urandom);
            poke(na, shadow[na]);
        end
        do_reset();
        last_ls_read = 8'h00;
        n_acks = 0;
        r_we = 0; r_wd = 0;
        for (int k = 0; k < 3; k++) begin pend[k] = 0; waits[k] = 0; r_a[k] = '0; end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) just[k] = 0;
            for (int k = 0; k < 3; k++) begin
                if (ack_of(2'(k))) begin
                    n_acks++;
                    just[k] = 1;
                    chk($sformatf("rnd_ack%0d_pending", k), 32'(pend[k]), 1);
                    chk($sformatf("rnd_ack%0d_fair", k), 32'(waits[k] <= 2), 1);
                    if (k == 0) begin
                        na = r_a[0] + 12'd1;
                        chk("rnd_fetch_data", 32'(fetch_opcode), 32'({shadow[r_a[0]], shadow[na]}));
                    end else if (k == 1) begin
                        chk("rnd_draw_data", 32'(draw_rdata), 32'(shadow[r_a[1]]));
                    end else if (r_we) begin
                        shadow[r_a[2]] = r_wd;
                        chk("rnd_ls_rdata_held", 32'(ls_rdata), 32'(last_ls_read));
                    end else begin
                        last_ls_read = shadow[r_a[2]];
                        chk("rnd_ls_data", 32'(ls_rdata), 32'(last_ls_read));
                    end
                    for (int j = 0; j < 3; j++) if (j != k && pend[j]) waits[j]++;
                    pend[k] = 0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (!pend[k] && !just[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1;
                    waits[k] = 0;
                    r_a[k] = rnd_addr();
                    if (k == 2) begin r_we = 1'($urandom); r_wd = 8'($urandom); end
                end
            end
            fetch_req = pend[0]; fetch_addr = r_a[0];
            draw_req  = pend[1]; draw_addr  = r_a[1];
            ls_req    = pend[2]; ls_addr    = r_a[2]; ls_we = r_we; ls_wdata = r_wd;
            tick();
        end
        fetch_req = 0; draw_req = 0; ls_req = 0;
        chk("rnd_progress", 32'(n_acks > 300), 1);
        for (int i = 0; i < 8; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
